// File: rtl/counter_seq_pkg.sv
// Shared definitions for the mod-N run controller:
// FSM state encoding and count-direction codes.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/counter_mod_n_updown.sv
// Mod-N up/down counter with synchronous load.
// wrap_nxt flags that an enabled step from the current count would wrap.
module counter_mod_n_updown
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] count,
    output logic             wrap_nxt
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] top_val;
    logic             at_end;

    assign top_val  = modulus - ONE;
    assign at_end   = (dir == DIR_DN) ? (count_q == '0) : (count_q == top_val);
    assign wrap_nxt = at_end;
    assign count    = count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (at_end) begin
                count_d = (dir == DIR_DN) ? top_val : '0;
            end else begin
                count_d = (dir == DIR_DN) ? count_q - ONE : count_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Run controller for a mod-N up/down counter: start/pause/abort,
// per-wrap pass counting and registered wrap/done/err pulses.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int PW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] modulus,
    input  logic [PW-1:0]    passes,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             wrap,
    output logic             done,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO_W = WIDTH'(2);
    localparam logic [PW-1:0]    ONE_P = PW'(1);

    state_e           state_q, state_d;
    logic             cfg_dir_q, cfg_dir_d;
    logic [WIDTH-1:0] cfg_mod_q, cfg_mod_d;
    logic [PW-1:0]    pass_left_q, pass_left_d;
    logic             busy_q, busy_d;
    logic             wrap_q, wrap_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             ld;
    logic [WIDTH-1:0] ld_val;
    logic             en;
    logic             wrap_nxt;
    logic             cfg_ok;

    assign cfg_ok = (modulus >= TWO_W) && (passes != '0);

    always_comb begin
        state_d     = state_q;
        cfg_dir_d   = cfg_dir_q;
        cfg_mod_d   = cfg_mod_q;
        pass_left_d = pass_left_q;
        wrap_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ld          = 1'b0;
        ld_val      = '0;
        en          = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && cfg_ok) begin
                    cfg_dir_d   = dir;
                    cfg_mod_d   = modulus;
                    pass_left_d = passes;
                    ld          = 1'b1;
                    ld_val      = (dir == DIR_DN) ? modulus - ONE_W : '0;
                    state_d     = ST_RUN;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            ST_RUN, ST_HOLD: begin
                if (abort) begin
                    ld      = 1'b1;
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_HOLD;
                end else begin
                    // Pause is a plain step gate: the release edge steps too.
                    en      = 1'b1;
                    state_d = ST_RUN;
                    if (wrap_nxt) begin
                        wrap_d      = 1'b1;
                        pass_left_d = pass_left_q - ONE_P;
                        if (pass_left_q == ONE_P) begin
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cfg_dir_q   <= 1'b0;
            cfg_mod_q   <= '0;
            pass_left_q <= '0;
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cfg_dir_q   <= cfg_dir_d;
            cfg_mod_q   <= cfg_mod_d;
            pass_left_q <= pass_left_d;
            busy_q      <= busy_d;
            wrap_q      <= wrap_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    counter_mod_n_updown #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (ld),
        .load_val (ld_val),
        .en       (en),
        .dir      (cfg_dir_q),
        .modulus  (cfg_mod_q),
        .count    (count),
        .wrap_nxt (wrap_nxt)
    );

    assign busy = busy_q;
    assign wrap = wrap_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed table-driven bench for counter_sequencer (WIDTH=3, PW=4),
// plus a hand-written busy-start / reset-in-HOLD sequence.
module tb_counter_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       dir;
    logic [2:0] modulus;
    logic [3:0] passes;
    logic       pause;
    logic       abort;
    logic [2:0] count;
    logic       busy;
    logic       wrap;
    logic       done;
    logic       err;

    typedef struct {
        logic       rst;
        logic       st;
        logic       dr;
        logic [2:0] md;
        logic [3:0] ps;
        logic       pa;
        logic       ab;
        logic [2:0] ec;
        logic       eb;
        logic       ew;
        logic       ed;
        logic       ee;
    } vec_t;

    vec_t tbl[$];
    int   n_checks;
    int   n_errors;

    counter_sequencer #(
        .WIDTH (3),
        .PW    (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .dir     (dir),
        .modulus (modulus),
        .passes  (passes),
        .pause   (pause),
        .abort   (abort),
        .count   (count),
        .busy    (busy),
        .wrap    (wrap),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic rst, input logic st,
                                input logic dr, input int md,
                                input int ps, input logic pa,
                                input logic ab, input int ec,
                                input logic eb, input logic ew,
                                input logic ed, input logic ee);
        vec_t v;
        v.rst = rst;
        v.st  = st;
        v.dr  = dr;
        v.md  = 3'(md);
        v.ps  = 4'(ps);
        v.pa  = pa;
        v.ab  = ab;
        v.ec  = 3'(ec);
        v.eb  = eb;
        v.ew  = ew;
        v.ed  = ed;
        v.ee  = ee;
        tbl.push_back(v);
    endfunction

    // idle/step vector: no command inputs
    function automatic void nop(input int ec, input logic eb,
                                input logic ew, input logic ed);
        add(0, 0, 0, 0, 0, 0, 0, ec, eb, ew, ed, 0);
    endfunction

    task automatic chk(input string name, input int idx,
                       input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s vec %0d: got %0d want %0d",
                     name, idx, got, want);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        reset   = v.rst;
        start   = v.st;
        dir     = v.dr;
        modulus = v.md;
        passes  = v.ps;
        pause   = v.pa;
        abort   = v.ab;
        @(posedge clk);
        #1;
        chk("count", idx, int'(count), int'(v.ec));
        chk("busy",  idx, int'(busy),  int'(v.eb));
        chk("wrap",  idx, int'(wrap),  int'(v.ew));
        chk("done",  idx, int'(done),  int'(v.ed));
        chk("err",   idx, int'(err),   int'(v.ee));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        start    = 1'b0;
        dir      = 1'b0;
        modulus  = '0;
        passes   = '0;
        pause    = 1'b0;
        abort    = 1'b0;

        // reset state
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 1, 5, 3, 0, 0, 0, 0, 0, 0, 0);
        // up run N=5 passes=1
        add(0, 1, 0, 5, 1, 0, 0, 0, 1, 0, 0, 0);
        nop(1, 1, 0, 0);
        nop(2, 1, 0, 0);
        nop(3, 1, 0, 0);
        nop(4, 1, 0, 0);
        nop(0, 0, 1, 1);
        // start during DONE is ignored
        add(0, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
        nop(0, 0, 0, 0);
        // down run N=3 passes=2
        add(0, 1, 1, 3, 2, 0, 0, 2, 1, 0, 0, 0);
        nop(1, 1, 0, 0);
        nop(0, 1, 0, 0);
        nop(2, 1, 1, 0);
        nop(1, 1, 0, 0);
        nop(0, 1, 0, 0);
        nop(2, 0, 1, 1);
        nop(2, 0, 0, 0);
        // illegal cfg: N=1, N=0, passes=0
        add(0, 1, 0, 1, 3, 0, 0, 2, 0, 0, 0, 1);
        nop(2, 0, 0, 0);
        add(0, 1, 1, 0, 3, 0, 0, 2, 0, 0, 0, 1);
        add(0, 1, 0, 5, 0, 0, 0, 2, 0, 0, 0, 1);
        nop(2, 0, 0, 0);
        // abort at count 3
        add(0, 1, 0, 5, 2, 0, 0, 0, 1, 0, 0, 0);
        nop(1, 1, 0, 0);
        nop(2, 1, 0, 0);
        nop(3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // abort ignored in IDLE: start still accepted
        add(0, 1, 1, 4, 1, 0, 1, 3, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // pause and abort together: abort wins
        add(0, 1, 0, 4, 1, 0, 0, 0, 1, 0, 0, 0);
        nop(1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        // pause over two edges at count 2
        add(0, 1, 0, 5, 1, 0, 0, 0, 1, 0, 0, 0);
        nop(1, 1, 0, 0);
        nop(2, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0);
        nop(3, 1, 0, 0);
        nop(4, 1, 0, 0);
        nop(0, 0, 1, 1);
        nop(0, 0, 0, 0);

        foreach (tbl[i]) apply(tbl[i], i);

        // busy start with N=3 must not disturb the running N=7 cfg,
        // then reset while in HOLD at a nonzero count
        begin
            vec_t v;
            int   k;
            k = 1000;
            v = '{0, 1, 0, 3'd7, 4'd2, 0, 0, 3'd0, 1, 0, 0, 0};
            apply(v, k++);
            for (int c = 1; c <= 3; c++) begin
                v = '{0, 0, 0, 3'd0, 4'd0, 0, 0, 3'(c), 1, 0, 0, 0};
                apply(v, k++);
            end
            v = '{0, 1, 1, 3'd3, 4'd1, 0, 0, 3'd4, 1, 0, 0, 0};
            apply(v, k++);
            v = '{0, 0, 0, 3'd0, 4'd0, 0, 0, 3'd5, 1, 0, 0, 0};
            apply(v, k++);
            v = '{0, 0, 0, 3'd0, 4'd0, 0, 0, 3'd6, 1, 0, 0, 0};
            apply(v, k++);
            v = '{0, 0, 0, 3'd0, 4'd0, 0, 0, 3'd0, 1, 1, 0, 0};
            apply(v, k++);
            v = '{0, 0, 0, 3'd0, 4'd0, 0, 0, 3'd1, 1, 0, 0, 0};
            apply(v, k++);
            v = '{0, 0, 0, 3'd0, 4'd0, 1, 0, 3'd1, 1, 0, 0, 0};
            apply(v, k++);
            v = '{0, 0, 0, 3'd0, 4'd0, 1, 0, 3'd1, 1, 0, 0, 0};
            apply(v, k++);
            v = '{1, 0, 0, 3'd0, 4'd0, 1, 0, 3'd0, 0, 0, 0, 0};
            apply(v, k++);
            v = '{0, 0, 0, 3'd0, 4'd0, 1, 0, 3'd0, 0, 0, 0, 0};
            apply(v, k++);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
